rrat_recovery_ctrl: RTL and testbench
=====================================

# rrat_recovery_ctrl

Sequences architectural-state recovery after a branch mispredict or exception in the 3-way R10K core. On an accepted flush it walks the retirement RAT, copies it into the front-end RAT a few entries per cycle, accumulates the set of live physical registers, then loads the rebuilt free-list mask in one shot. Sits between the ROB flush logic, the RRAT, the front-end RAT write ports and the free list. Holds the front end stalled for the whole sequence.

## Interface
Parameters:
- ARF_SIZE, 32, architectural registers; must be a multiple of COPY_W (elaboration check).
- PRF_SIZE, 64, physical registers.
- PRF_WIDTH, $clog2(PRF_SIZE), physical register number width.
- COPY_W, 4, RAT entries copied per cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- flush_req  in  1  mispredict/exception flush request.
- commit_busy  in  1  RRAT is being written this cycle.
- rrat_table_in  in  ARF_SIZE*PRF_WIDTH  flattened RRAT; entry i at [i*PRF_WIDTH +: PRF_WIDTH].
- flush_ack  out  1  one-cycle pulse when a flush is accepted.
- recov_busy  out  1  front-end stall; high from the first COPY cycle through LOAD.
- rat_wr_en  out  COPY_W  per-lane RAT write enable.
- rat_wr_arn  out  COPY_W*$clog2(ARF_SIZE)  per-lane architectural index.
- rat_wr_prn  out  COPY_W*PRF_WIDTH  per-lane physical number.
- fl_load  out  1  one-cycle pulse that loads fl_free_mask into the free list.
- fl_free_mask  out  PRF_SIZE  bit p = 1 means PRN p is free.
- recov_done  out  1  one-cycle pulse, coincident with fl_load.

## Operation
- FSM states: IDLE, WAIT, COPY, LOAD.
- IDLE:
  - flush_req & !commit_busy -> flush_ack, go to COPY.
  - flush_req & commit_busy -> flush_ack, go to WAIT.
- WAIT: stay while commit_busy is high; go to COPY on the first cycle it is low. The final RRAT write must land first.
- COPY: counter k runs 0..ARF_SIZE/COPY_W-1. Lane j writes arn = k*COPY_W+j, prn = RRAT[arn], and sets used[prn]. All lanes are enabled, including arn 0. Go to LOAD after the last k.
- LOAD: fl_free_mask = ~used, then fl_load = recov_done = 1. Clear used and k, return to IDLE.
- A flush_req outside IDLE is dropped: no flush_ack. The ROB is already flushed, so no new commits are pending.
- Duplicate PRNs in the RRAT are not checked; the OR-accumulation tolerates them.

## Timing
- Reset values: all outputs 0; state IDLE; k = 0; used = 0; fl_free_mask = 0.
- Acceptance at cycle t with commit_busy = 0, ARF_SIZE = 32, COPY_W = 4:
  - COPY occupies t+1..t+8.
  - LOAD is at t+9.
  - IDLE again at t+10.
  - recov_busy is high t+1..t+9.
- The earliest next acceptance is t+10.
- Each cycle spent in WAIT adds one cycle to this latency.
- All outputs are registered or decoded from registered state; there is no combinational input-to-output path.
- rst asserted mid-sequence aborts immediately to the reset values, with no partial fl_load. The RAT's contents are then undefined; the system reset also clears the RAT.

## Configuration
- RRAT_RECOVERY_SNAPSHOT_EN defined:
  - On acceptance, rrat_table_in is captured into an internal snapshot register, using the value sampled in the cycle commit_busy is low.
  - COPY reads the snapshot, so the sequence is immune to late RRAT writes.
- Not defined:
  - COPY reads rrat_table_in live each cycle.
  - Correctness relies on no commit during recovery.
  - Saves ARF_SIZE*PRF_WIDTH flops.

## Structure
- The shared r10k package holds:
  - the recov_state_e typedef (IDLE, WAIT, COPY, LOAD);
  - the ARF_SIZE/PRF_SIZE/COPY_W default constants.
- No sub-module: the FSM, counter, used-mask accumulator and optional snapshot fit in one file of about 200 lines.

## Test plan
- Reset then idle: all outputs 0 for 20 cycles with flush_req = 0.
- RRAT[i] = i+32, flush_req at t with commit_busy = 0:
  - flush_ack at t;
  - at t+1, lanes write arn 0..3 -> prn 32..35;
  - fl_load/recov_done at t+9 with fl_free_mask = 64'h0000_0000_FFFF_FFFF.
- flush_req with commit_busy high for 3 cycles: COPY starts 1 cycle after commit_busy falls; recov_busy is held throughout.
- flush_req pulsed again during COPY: no second flush_ack, and exactly one fl_load.
- All RRAT entries = 7: fl_free_mask has only bit 7 cleared.
- rst asserted at COPY k = 3:
  - outputs go to 0 asynchronously with no fl_load;
  - a fresh flush afterwards completes normally.
- With RRAT_RECOVERY_SNAPSHOT_EN, change rrat_table_in during COPY: the written PRNs match the captured values.

Source files
------------

// File: rtl/rrat_recovery_ctrl_pkg.sv
// Shared definitions for the R10K RRAT recovery controller: default sizes,
// recovery FSM state type and a small width helper.
package rrat_recovery_ctrl_pkg;

  localparam int RRAT_ARF_SIZE = 32;
  localparam int RRAT_PRF_SIZE = 64;
  localparam int RRAT_COPY_W   = 4;

  typedef enum logic [1:0] {
    RECOV_IDLE = 2'd0,
    RECOV_WAIT = 2'd1,
    RECOV_COPY = 2'd2,
    RECOV_LOAD = 2'd3
  } recov_state_e;

  // $clog2 that never yields a zero-width vector
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rrat_recovery_ctrl.sv
// Architectural-state recovery sequencer: on an accepted flush it copies the
// retirement RAT into the front-end RAT COPY_W entries per cycle, accumulates
// the live PRN set, then loads the complementary free-list mask in one pulse.
// Optional build macro: RRAT_RECOVERY_SNAPSHOT_EN (COPY reads a snapshot of
// the RRAT captured on entry to COPY instead of the live table).
// All outputs come straight from flops; the RAT write lanes are prepared one
// cycle ahead from the next-state counter so lane group k is visible in the
// cycle the FSM sits at COPY with counter k.
module rrat_recovery_ctrl
  import rrat_recovery_ctrl_pkg::*;
#(
  parameter int ARF_SIZE  = RRAT_ARF_SIZE,
  parameter int PRF_SIZE  = RRAT_PRF_SIZE,
  parameter int PRF_WIDTH = $clog2(PRF_SIZE),
  parameter int COPY_W    = RRAT_COPY_W
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush_req,
  input  logic                                 commit_busy,
  input  logic [ARF_SIZE*PRF_WIDTH-1:0]        rrat_table_in,
  output logic                                 flush_ack,
  output logic                                 recov_busy,
  output logic [COPY_W-1:0]                    rat_wr_en,
  output logic [COPY_W*$clog2(ARF_SIZE)-1:0]   rat_wr_arn,
  output logic [COPY_W*PRF_WIDTH-1:0]          rat_wr_prn,
  output logic                                 fl_load,
  output logic [PRF_SIZE-1:0]                  fl_free_mask,
  output logic                                 recov_done
);

  localparam int ARN_W = clog2_min1(ARF_SIZE);
  localparam int NGRP  = ARF_SIZE / COPY_W;
  localparam int K_W   = clog2_min1(NGRP);
  localparam logic [K_W-1:0] K_LAST = K_W'(NGRP - 1);

  localparam logic [1:0] ST_IDLE = RECOV_IDLE;
  localparam logic [1:0] ST_WAIT = RECOV_WAIT;
  localparam logic [1:0] ST_COPY = RECOV_COPY;
  localparam logic [1:0] ST_LOAD = RECOV_LOAD;

  if ((ARF_SIZE % COPY_W) != 0) begin : g_bad_cfg
    $error("ARF_SIZE must be a multiple of COPY_W");
  end

  logic [1:0]                     state_q, state_d;
  logic [K_W-1:0]                 k_q, k_d;
  logic [PRF_SIZE-1:0]            used_q, used_d;
  logic [PRF_SIZE-1:0]            mask_q, mask_d;
  logic                           ack_q, ack_d;
  logic                           busy_q, busy_d;
  logic                           load_q, load_d;
  logic [COPY_W-1:0]              wr_en_q, wr_en_d;
  logic [COPY_W*ARN_W-1:0]        arn_q, arn_d;
  logic [COPY_W*PRF_WIDTH-1:0]    prn_q, prn_d;
  logic [ARF_SIZE*PRF_WIDTH-1:0]  rrat_src;
  logic [ARN_W-1:0]               lane_arn [COPY_W];
  logic [PRF_WIDTH-1:0]           lane_prn [COPY_W];

`ifdef RRAT_RECOVERY_SNAPSHOT_EN
  logic [ARF_SIZE*PRF_WIDTH-1:0]  snap_q;

  // Capture the RRAT on the edge that enters COPY (commit_busy already low)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_q <= '0;
    end else if (state_d == ST_COPY && state_q != ST_COPY) begin
      snap_q <= rrat_table_in;
    end
  end

  // Group 0 is loaded on the capture edge itself, so it reads the live table
  assign rrat_src = (state_q == ST_COPY) ? snap_q : rrat_table_in;
`else
  assign rrat_src = rrat_table_in;
`endif

  // Per-lane index and RRAT lookup for the group about to be presented
  for (genvar gi = 0; gi < COPY_W; gi++) begin : g_lane
    assign lane_arn[gi] = ARN_W'(int'(k_d) * COPY_W + gi);
    assign lane_prn[gi] = rrat_src[int'(lane_arn[gi]) * PRF_WIDTH +: PRF_WIDTH];
  end

  // Recovery FSM, group counter and free-mask generation
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    ack_d   = 1'b0;
    load_d  = 1'b0;
    mask_d  = mask_q;
    case (state_q)
      ST_IDLE: begin
        if (flush_req) begin
          ack_d   = 1'b1;
          k_d     = '0;
          state_d = commit_busy ? ST_WAIT : ST_COPY;
        end
      end
      ST_WAIT: begin
        if (!commit_busy) begin
          state_d = ST_COPY;
          k_d     = '0;
        end
      end
      ST_COPY: begin
        if (k_q == K_LAST) begin
          state_d = ST_LOAD;
          mask_d  = ~used_q;
          load_d  = 1'b1;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_LOAD: begin
        state_d = ST_IDLE;
        k_d     = '0;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_COPY) || (state_d == ST_LOAD);
  end

  // RAT write lanes and live-PRN accumulation for the next COPY cycle
  always_comb begin
    wr_en_d = {COPY_W{state_d == ST_COPY}};
    arn_d   = '0;
    prn_d   = '0;
    used_d  = (state_q == ST_LOAD) ? '0 : used_q;
    if (state_d == ST_COPY) begin
      for (int j = 0; j < COPY_W; j++) begin
        arn_d[j*ARN_W +: ARN_W]         = lane_arn[j];
        prn_d[j*PRF_WIDTH +: PRF_WIDTH] = lane_prn[j];
        used_d[lane_prn[j]]             = 1'b1;
      end
    end
  end

  // State and output registers; reset aborts any sequence in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      used_q  <= '0;
      mask_q  <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      load_q  <= 1'b0;
      wr_en_q <= '0;
      arn_q   <= '0;
      prn_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      used_q  <= used_d;
      mask_q  <= mask_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      load_q  <= load_d;
      wr_en_q <= wr_en_d;
      arn_q   <= arn_d;
      prn_q   <= prn_d;
    end
  end

  assign flush_ack    = ack_q;
  assign recov_busy   = busy_q;
  assign rat_wr_en    = wr_en_q;
  assign rat_wr_arn   = arn_q;
  assign rat_wr_prn   = prn_q;
  assign fl_load      = load_q;
  assign recov_done   = load_q;
  assign fl_free_mask = mask_q;

endmodule

// File: tb/tb_rrat_recovery_ctrl.sv
// Self-checking bench for rrat_recovery_ctrl: directed cases plus randomized
// RRAT contents / commit_busy stalls, checked against a table-level model of
// the recovery (expected lane contents and free mask derived from the RRAT).
module tb_rrat_recovery_ctrl;

  localparam int ARF  = 32;
  localparam int PRF  = 64;
  localparam int PW   = 6;
  localparam int CW   = 4;
  localparam int AW   = 5;
  localparam int NGRP = ARF / CW;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 flush_req = 1'b0;
  logic                 commit_busy = 1'b0;
  logic [ARF*PW-1:0]    rrat_table_in = '0;
  logic                 flush_ack;
  logic                 recov_busy;
  logic [CW-1:0]        rat_wr_en;
  logic [CW*AW-1:0]     rat_wr_arn;
  logic [CW*PW-1:0]     rat_wr_prn;
  logic                 fl_load;
  logic [PRF-1:0]       fl_free_mask;
  logic                 recov_done;

  int n_cmp = 0;
  int n_bad = 0;
  int rrat_m [ARF];

  rrat_recovery_ctrl #(
    .ARF_SIZE(ARF), .PRF_SIZE(PRF), .PRF_WIDTH(PW), .COPY_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .flush_req(flush_req), .commit_busy(commit_busy),
    .rrat_table_in(rrat_table_in), .flush_ack(flush_ack),
    .recov_busy(recov_busy), .rat_wr_en(rat_wr_en), .rat_wr_arn(rat_wr_arn),
    .rat_wr_prn(rat_wr_prn), .fl_load(fl_load), .fl_free_mask(fl_free_mask),
    .recov_done(recov_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rrat();
    for (int i = 0; i < ARF; i++) rrat_table_in[i*PW +: PW] = PW'(rrat_m[i]);
  endtask

  function automatic logic [63:0] all_outputs();
    return 64'({flush_ack, recov_busy, rat_wr_en, fl_load, recov_done, rat_wr_arn, rat_wr_prn});
  endfunction

  // Free mask: every PRN free except those named somewhere in the RRAT
  function automatic logic [63:0] model_mask();
    logic [63:0] m;
    m = '1;
    for (int i = 0; i < ARF; i++) m[rrat_m[i]] = 1'b0;
    return m;
  endfunction

  task automatic run_flush(input int wait_cyc, input bit pulse_again, input bit mutate);
    logic [CW*AW-1:0] exp_arn;
    logic [CW*PW-1:0] exp_prn;
    drive_rrat();
    flush_req   = 1'b1;
    commit_busy = (wait_cyc > 0);
    step();
    check_eq("ack", 64'(flush_ack), 64'd1);
    flush_req = 1'b0;
    for (int c = 1; c <= wait_cyc; c++) begin
      check_eq("wait_wr_en", 64'(rat_wr_en), 64'd0);
      check_eq("wait_load", 64'(fl_load), 64'd0);
      if (c == wait_cyc) commit_busy = 1'b0;
      step();
    end
    for (int g = 0; g < NGRP; g++) begin
      for (int j = 0; j < CW; j++) begin
        exp_arn[j*AW +: AW] = AW'(g*CW + j);
        exp_prn[j*PW +: PW] = PW'(rrat_m[g*CW + j]);
      end
      if (g > 0 || wait_cyc > 0) check_eq("copy_ack", 64'(flush_ack), 64'd0);
      check_eq("copy_wr_en", 64'(rat_wr_en), 64'hF);
      check_eq("copy_arn", 64'(rat_wr_arn), 64'(exp_arn));
      check_eq("copy_prn", 64'(rat_wr_prn), 64'(exp_prn));
      check_eq("copy_busy", 64'(recov_busy), 64'd1);
      check_eq("copy_load", 64'(fl_load), 64'd0);
      if (pulse_again) flush_req = (g == 2);
`ifdef RRAT_RECOVERY_SNAPSHOT_EN
      if (mutate && g == 0)
        rrat_table_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
`else
      if (mutate && g == 0) $display("snapshot disabled: live-table mutation skipped");
`endif
      step();
    end
    flush_req = 1'b0;
    check_eq("load_pulse", 64'(fl_load), 64'd1);
    check_eq("load_done", 64'(recov_done), 64'd1);
    check_eq("load_mask", fl_free_mask, model_mask());
    check_eq("load_busy", 64'(recov_busy), 64'd1);
    check_eq("load_wr_en", 64'(rat_wr_en), 64'd0);
    step();
    check_eq("idle_pulses", 64'({flush_ack, recov_busy, fl_load, recov_done, rat_wr_en}), 64'd0);
    drive_rrat();
    $display("flush wait=%0d repulse=%0d mutate=%0d mask=%h", wait_cyc, pulse_again, mutate, model_mask());
  endtask

  task automatic run_abort();
    for (int i = 0; i < ARF; i++) rrat_m[i] = int'($urandom_range(0, PRF-1));
    drive_rrat();
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    for (int g = 1; g <= 3; g++) step();
    check_eq("abort_pre_wr_en", 64'(rat_wr_en), 64'hF);
    #2;
    rst = 1'b1;
    #1;
    check_eq("abort_outputs", all_outputs(), 64'd0);
    check_eq("abort_mask", fl_free_mask, 64'd0);
    step();
    check_eq("abort_hold", all_outputs(), 64'd0);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      check_eq("abort_no_load", 64'(fl_load), 64'd0);
    end
    $display("abort at k=3 done");
  endtask

  initial begin
    step();
    check_eq("rst_outputs", all_outputs(), 64'd0);
    check_eq("rst_mask", fl_free_mask, 64'd0);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      check_eq("idle_outputs", all_outputs(), 64'd0);
    end

    for (int i = 0; i < ARF; i++) rrat_m[i] = i + 32;
    run_flush(0, 1'b0, 1'b0);
    run_flush(3, 1'b0, 1'b0);
    run_flush(0, 1'b1, 1'b0);
    for (int i = 0; i < ARF; i++) rrat_m[i] = 7;
    run_flush(0, 1'b0, 1'b0);

    run_abort();
    for (int i = 0; i < ARF; i++) rrat_m[i] = ARF - 1 - i;
    run_flush(0, 1'b0, 1'b0);

    for (int i = 0; i < ARF; i++) rrat_m[i] = int'($urandom_range(0, PRF-1));
    run_flush(1, 1'b0, 1'b1);

    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < ARF; i++) rrat_m[i] = int'($urandom_range(0, PRF-1));
      run_flush(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
      for (int c = 0; c < int'($urandom_range(0, 2)); c++) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
